// File: rtl/jsil_seq_pkg.sv
// Shared definitions for the mode-1 program sequencer.
//   - seq_state_e : FSM state encoding, visible on the sequencer's state port
//   - ADDR_W_DEF  : default PC / ROM address width
//   - INSTR_W_DEF : default instruction width
package jsil_seq_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int INSTR_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/prog_seq.sv
// Program sequencer for mode-1 execution.
// Owns the program counter, fetches from an external combinational ROM and
// hands each instruction to the execute stage over a valid/ready handshake.
// Supports free run, single step, halt request, taken jumps and a single
// address breakpoint.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ena                 global enable; 0 freezes every register
//   run                 level, free-run while high
//   step                one-cycle pulse, one instruction from IDLE
//   halt_req            level, stop once the current instruction retires
//   rom_addr / rom_data ROM address (= pc) and combinational read data
//   instr, instr_valid  registered instruction towards execute
//   instr_ready         execute stage accepts instr
//   jump_en, jump_addr  sampled at the handshake, redirect the next pc
//   bkpt_en, bkpt_addr  halt before fetching the instruction at bkpt_addr
//   state, halted       FSM state (IDLE=0 FETCH=1 ISSUE=2 HALT=3), HALT flag
module prog_seq
  import jsil_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               bkpt_en,
  input  logic [ADDR_W-1:0]  bkpt_addr,
  output logic [1:0]         state,
  output logic               halted
);

  seq_state_e        st;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_pc;
  logic              single_step;
  logic              handshake;
  logic              bkpt_hit;

  // Increment wraps naturally at the address width; a taken jump wins.
  assign pc_inc    = pc + ADDR_W'(1);
  assign next_pc   = jump_en ? jump_addr : pc_inc;
  assign handshake = instr_valid && instr_ready;

  // The breakpoint is checked against the address about to be fetched, so
  // the instruction at bkpt_addr is never fetched before halting. On resume
  // the fetch at bkpt_addr is not compared again, only its successor is.
  assign bkpt_hit  = bkpt_en && (next_pc == bkpt_addr);

  assign rom_addr  = pc;
  assign state     = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      single_step <= 1'b0;
    end else if (ena) begin
      case (st)
        S_IDLE: begin
          // run wins over step, so a step pulse while running is ignored.
          if (run) begin
            st          <= S_FETCH;
            single_step <= 1'b0;
          end else if (step) begin
            st          <= S_FETCH;
            single_step <= 1'b1;
          end
        end

        // Fetch boundary: capture the ROM word, valid one cycle later.
        S_FETCH: begin
          instr       <= rom_data;
          instr_valid <= 1'b1;
          st          <= S_ISSUE;
        end

        // Issue boundary: instr/valid stay put until the execute stage takes
        // them; halt and run are only evaluated after the handshake so the
        // in-flight instruction always retires exactly once.
        S_ISSUE: begin
          if (handshake) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            single_step <= 1'b0;
            if (halt_req || bkpt_hit) begin
              st     <= S_HALT;
              halted <= 1'b1;
            end else if (single_step || !run) begin
              st <= S_IDLE;
            end else begin
              st <= S_FETCH;
            end
          end
        end

        S_HALT: begin
          if (!run && !halt_req) begin
            st     <= S_IDLE;
            halted <= 1'b0;
          end
        end

        default: begin
          st     <= S_IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_seq.sv
// Scoreboard bench for prog_seq. The driver predicts the instruction stream
// from the ROM image, the jump table and the pc rules, and queues it; a
// separate monitor pops one entry per handshake and also watches that a
// pending instruction is held stable.
module tb_prog_seq;

  logic       clk = 1'b0;
  logic       reset, ena, run, step, halt_req, instr_ready;
  logic       jump_en, bkpt_en;
  logic [3:0] rom_addr, jump_addr, bkpt_addr;
  logic [7:0] rom_data, instr;
  logic       instr_valid, halted;
  logic [1:0] state;

  logic [7:0] rom [16];
  assign rom_data = rom[rom_addr];

  prog_seq dut (
    .clk(clk), .reset(reset), .ena(ena), .run(run), .step(step),
    .halt_req(halt_req), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump_en(jump_en), .jump_addr(jump_addr), .bkpt_en(bkpt_en),
    .bkpt_addr(bkpt_addr), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  int         hs_cnt = 0;
  logic [7:0] exp_q[$];
  bit         jt_en   [1024];
  logic [3:0] jt_addr [1024];
  logic [3:0] model_pc;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Handshake counter, sampled at the clock edge that completes a transfer.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset && ena && instr_valid && instr_ready) hs_cnt++;
    end
  end

  // Monitor: compare each issued instruction with the predicted stream and
  // check that an unaccepted instruction does not move.
  initial begin
    logic       last_pend;
    logic [7:0] last_instr;
    logic [7:0] e;
    last_pend  = 1'b0;
    last_instr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_pend = 1'b0;
      end else begin
        if (last_pend) begin
          if (instr_valid) chk("instr_stable", instr, last_instr);
          else             chk("valid_held", 0, 1);
        end
        if (instr_valid && instr_ready && ena) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_issue", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("instr", instr, e);
          end
          last_pend = 1'b0;
        end else begin
          last_pend  = instr_valid;
          last_instr = instr;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
    jump_en   = jt_en[hs_cnt % 1024];
    jump_addr = jt_addr[hs_cnt % 1024];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    model_pc = 4'd0;
  endtask

  // Reference model: instruction k comes from the current pc; the pc then
  // follows the jump planned for that handshake or moves to pc+1 mod 16.
  task automatic expect_seq(input int n);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = (hs_cnt + k) % 1024;
      exp_q.push_back(rom[model_pc]);
      model_pc = jt_en[idx] ? jt_addr[idx] : model_pc + 4'd1;
    end
  endtask

  // Run until handshake number target is about to complete, dropping run
  // just before it so the sequencer returns to IDLE afterwards.
  task automatic run_to(input int target, input int maxc, input bit rnd, output int cyc);
    bit         found;
    bit         frozen;
    logic [1:0] st_saved;
    logic [3:0] pc_saved;
    found  = 1'b0;
    frozen = 1'b0;
    cyc    = 0;
    st_saved = '0;
    pc_saved = '0;
    run = 1'b1;
    while (!found && cyc < maxc) begin
      tick();
      cyc++;
      if (frozen) begin
        chk("ena_freeze_state", state, st_saved);
        chk("ena_freeze_pc", rom_addr, pc_saved);
      end
      if (rnd) begin
        ena         = ($urandom_range(0, 7) != 0);
        instr_ready = ($urandom_range(0, 2) != 0);
      end
      frozen   = !ena;
      st_saved = state;
      pc_saved = rom_addr;
      if (ena && instr_valid && instr_ready && hs_cnt == target - 1) begin
        run   = 1'b0;
        found = 1'b1;
      end
    end
    chk("run_to_done", found, 1);
    tick();
    ena = 1'b1;
    tick();
  endtask

  initial begin
    int cyc;
    int base;
    int n;
    bit ok;

    reset = 1'b1; ena = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    instr_ready = 1'b1; jump_en = 1'b0; jump_addr = '0;
    bkpt_en = 1'b0; bkpt_addr = '0; model_pc = '0;
    for (int i = 0; i < 1024; i++) begin
      jt_en[i]   = 1'b0;
      jt_addr[i] = '0;
    end
    for (int i = 0; i < 16; i++) rom[i] = 8'(i * 3);

    // Reset state.
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", rom_addr, 0);
    reset = 1'b0;
    tick();

    // Free run over the wrap: 20 instructions, one every two cycles.
    expect_seq(20);
    run_to(20, 100, 1'b0, cyc);
    chk("throughput_cycles", cyc, 40);
    chk("wrap_pc", rom_addr, model_pc);
    chk("run_idle_state", state, 0);

    // Taken jump at the handshake of pc=4.
    chk("jump_start_pc", rom_addr, 4);
    base = hs_cnt;
    jt_en[base % 1024]   = 1'b1;
    jt_addr[base % 1024] = 4'd9;
    expect_seq(3);
    run_to(base + 3, 100, 1'b0, cyc);
    jt_en[base % 1024] = 1'b0;
    chk("jump_pc", rom_addr, 11);

    // Single steps from reset.
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
    base = hs_cnt;
    for (int s = 0; s < 3; s++) begin
      expect_seq(1);
      step = 1'b1;
      tick();
      step = 1'b0;
      ok = 1'b0;
      for (int w = 0; w < 10 && !ok; w++) begin
        tick();
        ok = (hs_cnt == base + s + 1);
      end
      chk("step_done", ok, 1);
      tick();
      chk("step_idle", state, 0);
      chk("step_pc", rom_addr, model_pc);
    end
    chk("step_hs_total", hs_cnt - base, 3);
    chk("step_final_pc", rom_addr, 3);

    // A step pulse while disabled is lost.
    ena  = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    ena  = 1'b1;
    tick();
    tick();
    chk("step_lost_state", state, 0);
    chk("step_lost_hs", hs_cnt - base, 3);

    // Breakpoint at 6 from reset, then resume through it.
    do_reset();
    bkpt_en   = 1'b1;
    bkpt_addr = 4'd6;
    n = 0;
    do begin
      expect_seq(1);
      n++;
    end while (model_pc != 4'd6);
    base = hs_cnt;
    run  = 1'b1;
    ok   = 1'b0;
    for (int w = 0; w < 60 && !ok; w++) begin
      tick();
      ok = halted;
    end
    chk("bkpt_halted", halted, 1);
    chk("bkpt_state", state, 3);
    chk("bkpt_pc", rom_addr, 6);
    chk("bkpt_hs", hs_cnt - base, n);
    run = 1'b0;
    tick();
    tick();
    chk("bkpt_resume_idle", state, 0);
    chk("bkpt_resume_halted", halted, 0);
    base = hs_cnt;
    expect_seq(2);
    run_to(base + 2, 100, 1'b0, cyc);
    chk("bkpt_resume_pc", rom_addr, 8);
    bkpt_en = 1'b0;

    // Back-pressure in ISSUE, then halt request.
    instr_ready = 1'b0;
    base = hs_cnt;
    expect_seq(1);
    run = 1'b1;
    ok  = 1'b0;
    for (int w = 0; w < 10 && !ok; w++) begin
      tick();
      ok = instr_valid;
    end
    chk("stall_valid_up", instr_valid, 1);
    for (int w = 0; w < 5; w++) tick();
    chk("stall_valid_held", instr_valid, 1);
    chk("stall_state", state, 2);
    halt_req    = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    chk("halt_state", state, 3);
    chk("halt_flag", halted, 1);
    chk("halt_pc", rom_addr, model_pc);
    chk("halt_hs", hs_cnt - base, 1);
    halt_req = 1'b0;
    run      = 1'b0;
    tick();
    tick();
    chk("halt_release", state, 0);

    // Reset while an instruction waits in ISSUE.
    instr_ready = 1'b0;
    run = 1'b1;
    ok  = 1'b0;
    for (int w = 0; w < 10 && !ok; w++) begin
      tick();
      ok = instr_valid;
    end
    chk("midrst_valid_up", instr_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_state", state, 0);
    run = 1'b0;
    instr_ready = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    model_pc = 4'd0;
    tick();

    // Randomized run: random ROM, jumps, back-pressure and enable gaps.
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
    base = hs_cnt;
    for (int k = 0; k < 40; k++) begin
      jt_en[(base + k) % 1024]   = ($urandom_range(0, 3) == 0);
      jt_addr[(base + k) % 1024] = 4'($urandom_range(0, 15));
    end
    expect_seq(40);
    run_to(base + 40, 2000, 1'b1, cyc);
    instr_ready = 1'b1;
    tick();
    tick();
    chk("rand_pc", rom_addr, model_pc);
    chk("rand_idle", state, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
